conv_mac_sequencer: RTL and testbench
=====================================

# conv_mac_sequencer

Sequencing datapath of the convolution processor. It computes the full 1-D convolution Z[i] = Σ X[k]·Y[i−k] for two operand memories and writes the (sizeX+sizeY−1)-sample result into the Z memory. It sits upstream of the processor's control/status registers:
- `busy` and `done` feed the status register stage.
- `start` and the sizes arrive from the configuration register stage.

## Interface
- `DATA_WIDTH`, 8: width of X and Y samples (unsigned).
- `ADDR_WIDTH`, 5: X/Y memory address width; max operand length 2^ADDR_WIDTH.
- `ACC_WIDTH`, 16: accumulator and Z sample width.

- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  start request, sampled in IDLE only.
- `size_x`  in  ADDR_WIDTH+1  X length, latched at start.
- `size_y`  in  ADDR_WIDTH+1  Y length, latched at start.
- `memx_addr`  out  ADDR_WIDTH  X read address; X RAM returns data 1 cycle later.
- `memx_data`  in  DATA_WIDTH  X read data.
- `memy_addr`  out  ADDR_WIDTH  Y read address; same 1-cycle read latency.
- `memy_data`  in  DATA_WIDTH  Y read data.
- `memz_addr`  out  ADDR_WIDTH+1  Z write address.
- `memz_data`  out  ACC_WIDTH  Z write data.
- `memz_we`  out  1  Z write strobe, one cycle per result.
- `busy`  out  1  high from the cycle after accepted start until DONE exits.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **Sizes:** latched at start. Values above 2^ADDR_WIDTH are clamped to 2^ADDR_WIDTH. Output length L = size_x+size_y−1.
- **States:** IDLE, CLR, RD, MAC, WR, DONE.
- **IDLE:** start=1 → CLR with i=0. If either latched size is 0 → DONE directly, with no Z writes.
- **CLR:** acc←0; k←kmin = max(0, i−size_y+1); kmax = min(i, size_x−1).
- **RD:** drive memx_addr=k and memy_addr=i−k.
- **MAC:** acc ← acc + memx_data·memy_data.
  - Product is full 2·DATA_WIDTH bits, zero-extended or truncated to ACC_WIDTH.
  - k==kmax → WR; otherwise k←k+1 and return to RD.
- **WR:** memz_we=1, memz_addr=i, memz_data=acc. If i==L−1 → DONE; else i←i+1 and go to CLR.
- **DONE:** done=1 for one cycle, then IDLE.
- **Accumulation:** modulo 2^ACC_WIDTH (wrap) unless saturation is compiled in.
- **start while busy:** ignored. start held high in DONE's following IDLE cycle starts a new run.
- **Reset:** rstn=0 at any edge forces IDLE on that edge regardless of state. Reset values:
  - memx_addr, memy_addr, memz_addr, memz_data, memz_we, busy, done: all 0.
  - acc, i, k, latched sizes: all 0.
- **Outputs:** all registered. memz_addr and memz_data hold their values outside WR. memx_addr and memy_addr hold their last values outside RD.

## Timing
- The start edge is E0. CLR occupies the cycle after E0.
- Per output i with t_i terms: 2 + 2·t_i cycles (CLR, t_i×(RD, MAC), WR).
- done is high in the cycle beginning at E0 + 1 + Σ(2 + 2·t_i) edges. With a zero size, done is high the cycle after E0.
- busy is high from CLR through DONE inclusive.
- busy falls and IDLE resumes on the edge after done.
- Read data is sampled exactly one edge after RD presents the addresses.
- No back-pressure: the Z memory must accept a write every WR cycle.

## Configuration
- **Macro:** `CONV_MAC_SAT_EN`.
- **Defined:** the accumulator saturates at 2^ACC_WIDTH−1.
  - An addition that would overflow yields all-ones.
  - Once saturated, the value stays saturated until the next CLR.
- **Undefined:** wrap-around modulo 2^ACC_WIDTH, with no saturation logic synthesized.

## Test plan
- X=[1,2,3], Y=[1,1], sizes 3/2 → Z[0..3]=[1,3,5,3].
  - Exactly 4 memz_we pulses.
  - done 1+4+6+6+4=21 edges after start.
  - busy high 21 cycles.
- X=[255,255], Y=[255,255], ACC_WIDTH=16 → Z[1]=64514 without `CONV_MAC_SAT_EN`, 65535 with it.
  - Z[0]=Z[2]=65025 in both builds.
- size_x=0, size_y=4 → no memz_we.
  - done the cycle after start.
  - busy stays low.
- X=[7], Y=[3]; pulse start again 3 cycles into the run → the second start is ignored.
  - Single write Z[0]=21.
  - Exactly one done pulse.
- rstn=0 for one edge during MAC of a 4×4 run → the next cycle shows IDLE, busy=0, memz_we=0, done=0.
  - A subsequent start with X=[2], Y=[5] yields Z[0]=10.
- size_x=40, ADDR_WIDTH=5 → clamped to 32.
  - With size_y=1, 32 writes at memz_addr 0..31.
  - Each Z[i]=X[i]·Y[0].

Source files
------------

// File: rtl/conv_mac_sequencer.sv
// Full 1-D convolution sequencer: Z[i] = sum_k X[k]*Y[i-k], one MAC per RD/MAC cycle pair.
// Optional build macro CONV_MAC_SAT_EN: saturating accumulator instead of wrap-around.
module conv_mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   size_x,
    input  logic [ADDR_WIDTH:0]   size_y,
    output logic [ADDR_WIDTH-1:0] memx_addr,
    input  logic [DATA_WIDTH-1:0] memx_data,
    output logic [ADDR_WIDTH-1:0] memy_addr,
    input  logic [DATA_WIDTH-1:0] memy_data,
    output logic [ADDR_WIDTH:0]   memz_addr,
    output logic [ACC_WIDTH-1:0]  memz_data,
    output logic                  memz_we,
    output logic                  busy,
    output logic                  done
);

    localparam int SW = ADDR_WIDTH + 1;
    localparam int W  = ADDR_WIDTH + 2;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [SW-1:0] MAX_SIZE = SW'(1 << ADDR_WIDTH);
    localparam logic [W-1:0]  W_ONE    = W'(1);
    localparam logic [W-1:0]  W_TWO    = W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RD,
        S_MAC,
        S_WR,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           sx_q, sx_d, sy_q, sy_d;
    logic [W-1:0]            i_q, i_d, k_q, k_d, kmax_q, kmax_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]   memx_addr_q, memx_addr_d, memy_addr_q, memy_addr_d;
    logic [SW-1:0]           memz_addr_q, memz_addr_d;
    logic [ACC_WIDTH-1:0]    memz_data_q, memz_data_d;
    logic                    memz_we_q, memz_we_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [SW-1:0]           sx_in, sy_in;
    logic [W-1:0]            i_p1, sy_w, sx_m1, kmin, kmax_c, y_cur, k_nxt, y_nxt;
    logic [PW-1:0]           prod;
    logic [ACC_WIDTH-1:0]    acc_sum;
    logic                    last_i;

    function automatic logic [SW-1:0] clamp_size(input logic [SW-1:0] s);
        return (s > MAX_SIZE) ? MAX_SIZE : s;
    endfunction

    // Product is zero-extended or truncated to the accumulator width before the add.
    function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [PW-1:0]        p);
        logic [ACC_WIDTH-1:0] pe;
`ifdef CONV_MAC_SAT_EN
        logic [ACC_WIDTH:0] sum;
        pe  = ACC_WIDTH'(p);
        sum = {1'b0, a} + {1'b0, pe};
        return sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
        pe = ACC_WIDTH'(p);
        return a + pe;
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        i_d         = i_q;
        k_d         = k_q;
        kmax_d      = kmax_q;
        acc_d       = acc_q;
        memx_addr_d = memx_addr_q;
        memy_addr_d = memy_addr_q;
        memz_addr_d = memz_addr_q;
        memz_data_d = memz_data_q;
        memz_we_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;

        sx_in   = clamp_size(size_x);
        sy_in   = clamp_size(size_y);
        i_p1    = i_q + W_ONE;
        sy_w    = W'(sy_q);
        sx_m1   = W'(sx_q) - W_ONE;
        kmin    = (i_p1 > sy_w) ? (i_p1 - sy_w) : '0;
        kmax_c  = (i_q < sx_m1) ? i_q : sx_m1;
        y_cur   = i_q - kmin;
        k_nxt   = k_q + W_ONE;
        y_nxt   = i_q - k_nxt;
        prod    = PW'(memx_data) * PW'(memy_data);
        acc_sum = acc_add(acc_q, prod);
        last_i  = ((i_q + W_TWO) == (W'(sx_q) + W'(sy_q)));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sx_d = sx_in;
                    sy_d = sy_in;
                    i_d  = '0;
                    if ((sx_in == '0) || (sy_in == '0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CLR;
                        busy_d  = 1'b1;
                    end
                end
            end
            // Addresses are launched on entry to RD so the RAM sees them during RD.
            S_CLR: begin
                acc_d       = '0;
                k_d         = kmin;
                kmax_d      = kmax_c;
                memx_addr_d = ADDR_WIDTH'(kmin);
                memy_addr_d = ADDR_WIDTH'(y_cur);
                state_d     = S_RD;
            end
            S_RD: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_sum;
                if (k_q == kmax_q) begin
                    state_d     = S_WR;
                    memz_we_d   = 1'b1;
                    memz_addr_d = SW'(i_q);
                    memz_data_d = acc_sum;
                end else begin
                    k_d         = k_nxt;
                    memx_addr_d = ADDR_WIDTH'(k_nxt);
                    memy_addr_d = ADDR_WIDTH'(y_nxt);
                    state_d     = S_RD;
                end
            end
            S_WR: begin
                if (last_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    i_d     = i_p1;
                    state_d = S_CLR;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            sx_q        <= '0;
            sy_q        <= '0;
            i_q         <= '0;
            k_q         <= '0;
            kmax_q      <= '0;
            acc_q       <= '0;
            memx_addr_q <= '0;
            memy_addr_q <= '0;
            memz_addr_q <= '0;
            memz_data_q <= '0;
            memz_we_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            i_q         <= i_d;
            k_q         <= k_d;
            kmax_q      <= kmax_d;
            acc_q       <= acc_d;
            memx_addr_q <= memx_addr_d;
            memy_addr_q <= memy_addr_d;
            memz_addr_q <= memz_addr_d;
            memz_data_q <= memz_data_d;
            memz_we_q   <= memz_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign memx_addr = memx_addr_q;
    assign memy_addr = memy_addr_q;
    assign memz_addr = memz_addr_q;
    assign memz_data = memz_data_q;
    assign memz_we   = memz_we_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer: directed and random runs against a plain-arithmetic convolution model.
module tb_conv_mac_sequencer;

    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int ACCW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   size_x = '0;
    logic [AW:0]   size_y = '0;
    logic [AW-1:0] memx_addr, memy_addr;
    logic [DW-1:0] memx_data = '0;
    logic [DW-1:0] memy_data = '0;
    logic [AW:0]   memz_addr;
    logic [ACCW-1:0] memz_data;
    logic          memz_we, busy, done;

    always #5 clk = ~clk;

    conv_mac_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .size_x(size_x), .size_y(size_y),
        .memx_addr(memx_addr), .memx_data(memx_data),
        .memy_addr(memy_addr), .memy_data(memy_data),
        .memz_addr(memz_addr), .memz_data(memz_data), .memz_we(memz_we),
        .busy(busy), .done(done)
    );

    // Operand RAMs with one-cycle synchronous read.
    logic [DW-1:0] xmem [32];
    logic [DW-1:0] ymem [32];
    always @(posedge clk) begin
        memx_data <= xmem[memx_addr];
        memy_data <= ymem[memy_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; longint data; } wr_t;
    wr_t wr_q[$];
    int  busy_total = 0;
    int  done_total = 0;
    int  last_done_cyc = -1;

    always @(negedge clk) begin
        if (memz_we === 1'b1) wr_q.push_back('{int'(memz_addr), longint'(memz_data)});
        if (busy === 1'b1) busy_total++;
        if (done === 1'b1) begin
            done_total++;
            last_done_cyc = cyc;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    longint z_exp [64];
    int     exp_len;
    int     exp_lat;

    // Reference: direct convolution sum, then wrap or clamp to the accumulator range.
    task automatic model(input int sx, input int sy);
        int sxc, syc, t, j;
        longint acc, top;
        top = (longint'(1) << ACCW) - 1;
        sxc = (sx > 32) ? 32 : sx;
        syc = (sy > 32) ? 32 : sy;
        exp_len = (sxc == 0 || syc == 0) ? 0 : sxc + syc - 1;
        exp_lat = 1;
        for (int i = 0; i < exp_len; i++) begin
            acc = 0;
            t = 0;
            for (int k = 0; k < sxc; k++) begin
                j = i - k;
                if (j >= 0 && j < syc) begin
                    acc += longint'(xmem[k]) * longint'(ymem[j]);
                    t++;
                end
            end
`ifdef CONV_MAC_SAT_EN
            z_exp[i] = (acc > top) ? top : acc;
`else
            z_exp[i] = acc % (top + 1);
`endif
            exp_lat += 2 + 2 * t;
        end
    endtask

    task automatic run_conv(input string tag, input int sx, input int sy, input int restart_at);
        int wb, bb, db, e0, nw;
        model(sx, sy);
        wb = wr_q.size();
        bb = busy_total;
        db = done_total;
        @(posedge clk); #1;
        size_x = sx[AW:0];
        size_y = sy[AW:0];
        start  = 1'b1;
        e0     = cyc;
        for (int n = 0; n < 6000 && done_total == db; n++) begin
            @(posedge clk); #1;
            start = (n == restart_at);
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        nw = wr_q.size() - wb;
        check_eq({tag, "_done_pulses"}, done_total - db, 1);
        check_eq({tag, "_latency"}, last_done_cyc - e0, exp_lat);
        check_eq({tag, "_busy_cycles"}, busy_total - bb, (exp_len == 0) ? 0 : exp_lat);
        check_eq({tag, "_writes"}, nw, exp_len);
        for (int i = 0; i < exp_len; i++) begin
            check_eq($sformatf("%s_zaddr%0d", tag, i), (i < nw) ? wr_q[wb + i].addr : -1, i);
            check_eq($sformatf("%s_zdata%0d", tag, i), (i < nw) ? wr_q[wb + i].data : -1, z_exp[i]);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            xmem[i] = DW'($urandom);
            ymem[i] = DW'($urandom);
        end
    endtask

    initial begin
        int wb, db, sx, sy;
        fill_random();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_we", memz_we, 0);
        check_eq("rst_zaddr", memz_addr, 0);
        check_eq("rst_zdata", memz_data, 0);
        check_eq("rst_xaddr", memx_addr, 0);
        check_eq("rst_yaddr", memy_addr, 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        fill_random();
        xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
        ymem[0] = 8'd1; ymem[1] = 8'd1;
        run_conv("basic", 3, 2, -1);

        xmem[0] = 8'd255; xmem[1] = 8'd255;
        ymem[0] = 8'd255; ymem[1] = 8'd255;
        run_conv("ovf", 2, 2, -1);

        run_conv("zero", 0, 4, -1);

        xmem[0] = 8'd7; ymem[0] = 8'd3;
        run_conv("restart", 1, 1, 2);

        // Reset asserted for one edge while the first MAC of a 4x4 run is in progress.
        fill_random();
        wb = wr_q.size();
        db = done_total;
        @(posedge clk); #1;
        size_x = 6'd4; size_y = 6'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_we", memz_we, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_zaddr", memz_addr, 0);
        check_eq("midrst_zdata", memz_data, 0);
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("midrst_no_writes", wr_q.size() - wb, 0);
        check_eq("midrst_no_done", done_total - db, 0);
        check_eq("midrst_idle_busy", busy, 0);
        xmem[0] = 8'd2; ymem[0] = 8'd5;
        run_conv("after_rst", 1, 1, -1);

        fill_random();
        run_conv("clamp", 40, 1, -1);

        for (int r = 0; r < 5; r++) begin
            fill_random();
            sx = $urandom_range(0, 34);
            sy = $urandom_range(0, 34);
            run_conv($sformatf("rand%0d", r), sx, sy, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
